conv_scan_controller: RTL

//  Sequencer for the 3x3 image-convolution datapath inside convolution_top.
//  On start it zero-fills the output image, then raster-scans the input image
//  and issues one read per pixel. It tags each complete 3x3 window with its

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_tag_delay.sv | 27 ++
 rtl/conv_scan_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution scan sequencer.
// FSM encodings and default latencies.
package conv_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;

  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_PIPE_LAT = 3;

  // Centre of a full 3x3 window exists once two rows/cols are buffered
  function automatic logic win_full(input logic [15:0] x,
                                    input logic [15:0] y);
    return (x >= 16'd2) && (y >= 16'd2);
  endfunction

endpackage

// File: rtl/conv_tag_delay.sv
// Fixed-depth shift register with async reset.
// Carries {valid,addr} tags or single strobes.
module conv_tag_delay #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  // Unconditional shift, one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/conv_scan_controller.sv
// Frame sequencer: zero-fill output, raster-scan input,
// and time-align window tags with the datapath.
module conv_scan_controller
  import conv_pkg::*;
#(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              lb_shift,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_zero,
  output logic [2:0]        state,
  output logic [15:0]       x_count,
  output logic [15:0]       y_count
);

  localparam int D  = RD_LAT + PIPE_LAT;
  localparam int FW = $clog2(D + 1);

  localparam logic [ADDR_W-1:0] A_LAST =
    ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] A_BACK =
    ADDR_W'(IMG_W + 1);
  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);
  localparam logic [FW-1:0] F_LAST = FW'(D - 1);

  logic [2:0]        st_q;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       x_q;
  logic [15:0]       y_q;
  logic [FW-1:0]     fl_cnt;
  logic              done_q;

  logic              issue;
  logic              tag_v_in;
  logic [ADDR_W-1:0] tag_a_in;
  logic              tag_v;
  logic [ADDR_W-1:0] tag_a;

  assign issue    = (st_q == ST_SCAN) && out_ready;
  assign tag_v_in = issue && win_full(x_q, y_q);
  assign tag_a_in = tag_v_in ? rd_addr - A_BACK : '0;

  conv_tag_delay #(
    .W     (ADDR_W + 1),
    .DEPTH (D)
  ) u_tag (
    .clk (clk),
    .rst (rst),
    .d   ({tag_v_in, tag_a_in}),
    .q   ({tag_v, tag_a})
  );

  conv_tag_delay #(
    .W     (1),
    .DEPTH (RD_LAT)
  ) u_lb (
    .clk (clk),
    .rst (rst),
    .d   (issue),
    .q   (lb_shift)
  );

  // Phase sequencing and scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      clr_addr <= '0;
      rd_addr  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fl_cnt   <= '0;
      done_q   <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            st_q     <= ST_CLEAR;
            done_q   <= 1'b0;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (out_ready) begin
            if (clr_addr == A_LAST) begin
              st_q    <= ST_SCAN;
              rd_addr <= '0;
              x_q     <= '0;
              y_q     <= '0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (out_ready) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              st_q   <= ST_FLUSH;
              fl_cnt <= '0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
              end else begin
                x_q <= x_q + 1'b1;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (fl_cnt == F_LAST) begin
            st_q   <= ST_IDLE;
            done_q <= 1'b1;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  // Write port: zero-fill in CLEAR, aligned tags afterwards
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_zero = 1'b0;
    unique case (1'b1)
      (st_q == ST_CLEAR): begin
        wr_en   = out_ready;
        wr_addr = clr_addr;
        wr_zero = 1'b1;
      end
      (st_q == ST_SCAN),
      (st_q == ST_FLUSH): begin
        wr_en   = tag_v;
        wr_addr = tag_a;
      end
      default: ;
    endcase
  end

  assign busy        = (st_q != ST_IDLE);
  assign done        = done_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_addr;
  assign state       = st_q;
  assign x_count     = x_q;
  assign y_count     = y_q;

endmodule
